// File: rtl/pll_sup_pkg.sv
// Shared types and counter widths for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    MEASURE,
    RUN,
    FAILED
  } sup_state_t;

  // Timer covers the longest interval (lock timeout / measurement window).
  localparam int TIMER_W = 17;
  // Edge counter width; matches the edge_count port.
  localparam int EDGE_W  = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the board PLL reset, qualifies lock and checks the slow PLL output
// frequency by counting its rising edges in the refclk domain. Retries on
// failure and produces the system reset / ready flag for the datapath.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 50,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int WINDOW        = 50000,
  parameter int EXP_EDGES     = 1500,
  parameter int TOL           = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        mon_clk,
  output logic        pll_rst,
  output logic        sys_rst,
  output logic        ready,
  output logic        fail,
  output logic [1:0]  retry_cnt,
  output logic [15:0] edge_count
);

  // Terminal timer values: each interval runs from 0 up to N-1.
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WINDOW_LAST = TIMER_W'(WINDOW - 1);
  localparam logic [1:0]         RETRY_MAX   = 2'(MAX_RETRY);

  sup_state_t          state, state_nxt;
  logic [TIMER_W-1:0]  timer, timer_nxt;
  logic [EDGE_W-1:0]   cnt, cnt_nxt, cnt_total;
  logic [EDGE_W-1:0]   edge_count_nxt;
  logic [1:0]          retry_nxt;
  logic                do_retry;
  logic                locked_s;
  logic                mon_s;
  logic                mon_p2;
  logic                edge_pulse;

  // Saturating increment of the edge counter.
  function automatic logic [EDGE_W-1:0] sat_inc(input logic [EDGE_W-1:0] c,
                                                input logic              p);
    if (p && (c != {EDGE_W{1'b1}})) return c + EDGE_W'(1);
    return c;
  endfunction

  // Inclusive tolerance band around the expected edge count.
  function automatic logic in_tol(input logic [EDGE_W-1:0] c);
    int v;
    v = int'(c);
    return (v >= EXP_EDGES - TOL) && (v <= EXP_EDGES + TOL);
  endfunction

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  sync_2ff u_mon_sync (
    .clk (refclk),
    .rst (rst),
    .d   (mon_clk),
    .q   (mon_s)
  );

  assign edge_pulse = mon_s & ~mon_p2;
  assign cnt_total  = sat_inc(cnt, edge_pulse);

  // State register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state <= RESET_PLL;
    else     state <= state_nxt;
  end

  // Next-state, timer, edge counter and retry bookkeeping.
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer + TIMER_W'(1);
    cnt_nxt        = '0;
    edge_count_nxt = edge_count;
    retry_nxt      = retry_cnt;
    do_retry       = 1'b0;

    case (state)
      RESET_PLL: begin
        if (timer == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          timer_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_nxt = STABILIZE;
          timer_nxt = '0;
        end else if (timer == LOCK_LAST) begin
          do_retry = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          do_retry = 1'b1;
        end else if (timer == STABLE_LAST) begin
          state_nxt = MEASURE;
          timer_nxt = '0;
        end
      end
      MEASURE, RUN: begin
        cnt_nxt = cnt_total;
        if (timer == WINDOW_LAST) begin
          // Result is published even if lock drops in this same cycle.
          timer_nxt      = '0;
          cnt_nxt        = '0;
          edge_count_nxt = cnt_total;
          if (locked_s && in_tol(cnt_total)) state_nxt = RUN;
          else                               do_retry  = 1'b1;
        end else if (!locked_s) begin
          do_retry = 1'b1;
        end
      end
      FAILED: begin
        timer_nxt = timer;
      end
      default: begin
        state_nxt = RESET_PLL;
        timer_nxt = '0;
      end
    endcase

    if (do_retry) begin
      timer_nxt = '0;
      cnt_nxt   = '0;
      if (retry_cnt >= RETRY_MAX) begin
        state_nxt = FAILED;
      end else begin
        retry_nxt = retry_cnt + 2'd1;
        state_nxt = RESET_PLL;
      end
    end
  end

  // Counters and registered outputs, decoded from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      timer      <= '0;
      cnt        <= '0;
      mon_p2     <= 1'b0;
      edge_count <= '0;
      retry_cnt  <= '0;
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      timer      <= timer_nxt;
      cnt        <= cnt_nxt;
      mon_p2     <= mon_s;
      edge_count <= edge_count_nxt;
      retry_cnt  <= retry_nxt;
      pll_rst    <= (state_nxt == RESET_PLL) || (state_nxt == FAILED);
      sys_rst    <= (state_nxt != RUN);
      ready      <= (state_nxt == RUN);
      fail       <= (state_nxt == FAILED);
    end
  end

endmodule
